// File: rtl/text_terminal.sv
// Character-cell VGA text terminal with CR/LF/BS/FF handling and ring scroll.
// Optional underline cursor blink: define TERMINAL_CURSOR_EN.
module text_terminal #(
  parameter int          COLS   = 32,
  parameter int          ROWS   = 15,
  parameter logic [11:0] FG_RGB = 12'h0F0,
  parameter logic [11:0] BG_RGB = 12'h000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [8:0]  hpos,
  input  logic [8:0]  vpos,
  input  logic        display_on,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        wr_valid,
  input  logic [7:0]  wr_data,
  output logic        wr_ready,
  output logic [7:0]  glyph_char,
  output logic [3:0]  glyph_row,
  input  logic [7:0]  glyph_bits,
  output logic [11:0] rgb,
  output logic        hsync_out,
  output logic        vsync_out
);

  localparam int N  = COLS * ROWS;
  localparam int AW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, CLRALL, CLRROW} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [5:0]    cur_col_q, cur_col_d;
  logic [4:0]    cur_row_q, cur_row_d;
  logic [4:0]    top_row_q, top_row_d;

  logic          we;
  logic [AW-1:0] waddr;
  logic [7:0]    wdata;
  logic          nl;
  logic [4:0]    bot_row;

  logic [7:0]    mem [N];

  function automatic logic [4:0] phys_row(input logic [4:0] lr,
                                          input logic [4:0] top);
    logic [5:0] s;
    s = {1'b0, lr} + {1'b0, top};
    if (s >= 6'(ROWS)) s = s - 6'(ROWS);
    return s[4:0];
  endfunction

  function automatic logic [AW-1:0] addr_of(input logic [4:0] pr,
                                            input logic [5:0] c);
    return AW'(pr) * AW'(COLS) + AW'(c);
  endfunction

  assign bot_row = (top_row_q == 5'd0) ? 5'(ROWS - 1) : top_row_q - 5'd1;

  // Control FSM: byte interpretation, cursor motion and clear sequencing
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cur_col_d = cur_col_q;
    cur_row_d = cur_row_q;
    top_row_d = top_row_q;
    we        = 1'b0;
    waddr     = '0;
    wdata     = 8'h20;
    wr_ready  = 1'b0;
    nl        = 1'b0;
    unique case (state_q)
      IDLE: begin
        wr_ready = 1'b1;
        if (wr_valid) begin
          unique case (wr_data)
            8'h0D: cur_col_d = 6'd0;
            8'h0A: begin
              cur_col_d = 6'd0;
              nl        = 1'b1;
            end
            8'h08: if (cur_col_q != 6'd0) cur_col_d = cur_col_q - 6'd1;
            8'h0C: begin
              state_d = CLRALL;
              cnt_d   = '0;
            end
            default: begin
              we    = 1'b1;
              waddr = addr_of(phys_row(cur_row_q, top_row_q), cur_col_q);
              wdata = wr_data;
              if (cur_col_q < 6'(COLS - 1)) begin
                cur_col_d = cur_col_q + 6'd1;
              end else begin
                cur_col_d = 6'd0;
                nl        = 1'b1;
              end
            end
          endcase
          if (nl) begin
            if (cur_row_q < 5'(ROWS - 1)) begin
              cur_row_d = cur_row_q + 5'd1;
            end else begin
              top_row_d = (top_row_q == 5'(ROWS - 1)) ? 5'd0
                                                      : top_row_q + 5'd1;
              state_d   = CLRROW;
              cnt_d     = '0;
            end
          end
        end
      end
      CLRALL: begin
        we    = 1'b1;
        waddr = cnt_q;
        if (cnt_q == AW'(N - 1)) begin
          state_d   = IDLE;
          cnt_d     = '0;
          cur_col_d = 6'd0;
          cur_row_d = 5'd0;
          top_row_d = 5'd0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      CLRROW: begin
        we    = 1'b1;
        waddr = addr_of(bot_row, 6'd0) + cnt_q;
        if (cnt_q == AW'(COLS - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = CLRALL;
    endcase
  end

  // Control state registers; reset restarts the full clear
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= CLRALL;
      cnt_q     <= '0;
      cur_col_q <= 6'd0;
      cur_row_q <= 5'd0;
      top_row_q <= 5'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cur_col_q <= cur_col_d;
      cur_row_q <= cur_row_d;
      top_row_q <= top_row_d;
    end
  end

  // Character RAM write port
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  logic [5:0]    cell_col;
  logic [4:0]    cell_row;
  logic          in_rng;
  logic [AW-1:0] rd_addr;

  assign cell_col = hpos[8:3];
  assign cell_row = vpos[8:4];
  assign in_rng   = ({1'b0, cell_col} < 7'(COLS)) &&
                    ({1'b0, cell_row} < 6'(ROWS));
  assign rd_addr  = in_rng ? addr_of(phys_row(cell_row, top_row_q), cell_col)
                           : '0;

  logic [7:0] char_q;
  logic [3:0] yofs_q;
  logic [2:0] xofs_q;
  logic       disp1_q, rng1_q, hs1_q, vs1_q;
  logic       pix_q, pix_d, disp2_q, hs2_q, vs2_q;
  logic       cursor_on;

`ifdef TERMINAL_CURSOR_EN
  logic       vs_prev_q;
  logic [5:0] frame_q, frame_d;
  logic       hit1_q;

  // Frame counter advances on each vsync rising edge
  always_comb begin
    frame_d = frame_q;
    if (vsync_in && !vs_prev_q) frame_d = frame_q + 6'd1;
  end

  // Blink counter and cursor-cell hit aligned with stage 1
  always_ff @(posedge clk) begin
    if (reset) begin
      vs_prev_q <= 1'b0;
      frame_q   <= 6'd0;
      hit1_q    <= 1'b0;
    end else begin
      vs_prev_q <= vsync_in;
      frame_q   <= frame_d;
      hit1_q    <= (cell_col == cur_col_q) && (cell_row == cur_row_q);
    end
  end

  assign cursor_on = frame_q[5] && hit1_q &&
                     (yofs_q == 4'd13 || yofs_q == 4'd14);
`else
  assign cursor_on = 1'b0;
`endif

  // Stage 1 pixel select from the combinational glyph reply
  always_comb begin
    pix_d = rng1_q &&
            (((yofs_q < 4'd12) && glyph_bits[3'd7 - xofs_q]) || cursor_on);
  end

  // Display pipeline: RAM read, then pixel, with matching sync delay
  always_ff @(posedge clk) begin
    if (reset) begin
      char_q  <= 8'd0;
      yofs_q  <= 4'd0;
      xofs_q  <= 3'd0;
      disp1_q <= 1'b0;
      rng1_q  <= 1'b0;
      hs1_q   <= 1'b0;
      vs1_q   <= 1'b0;
      pix_q   <= 1'b0;
      disp2_q <= 1'b0;
      hs2_q   <= 1'b0;
      vs2_q   <= 1'b0;
    end else begin
      char_q  <= mem[rd_addr];
      yofs_q  <= vpos[3:0];
      xofs_q  <= hpos[2:0];
      disp1_q <= display_on;
      rng1_q  <= in_rng;
      hs1_q   <= hsync_in;
      vs1_q   <= vsync_in;
      pix_q   <= pix_d;
      disp2_q <= disp1_q;
      hs2_q   <= hs1_q;
      vs2_q   <= vs1_q;
    end
  end

  // Final colour mux
  always_comb begin
    rgb = 12'h000;
    if (disp2_q) rgb = pix_q ? FG_RGB : BG_RGB;
  end

  assign glyph_char = char_q;
  assign glyph_row  = yofs_q;
  assign hsync_out  = hs2_q;
  assign vsync_out  = vs2_q;

endmodule

// File: tb/tb_text_terminal.sv
// Directed bench for text_terminal: clear, write, wrap, controls, scroll.
// Glyph ROM model: 'A' row 0 = 8'h80, 'B' all rows = 8'hFF, else blank.
module tb_text_terminal;

  logic        clk = 1'b0;
  logic        reset;
  logic [8:0]  hpos, vpos;
  logic        display_on, hsync_in, vsync_in;
  logic        wr_valid;
  logic [7:0]  wr_data;
  logic        wr_ready;
  logic [7:0]  glyph_char;
  logic [3:0]  glyph_row;
  logic [7:0]  glyph_bits;
  logic [11:0] rgb;
  logic        hsync_out, vsync_out;

  int checks = 0;
  int errors = 0;

  text_terminal dut (
    .clk        (clk),
    .reset      (reset),
    .hpos       (hpos),
    .vpos       (vpos),
    .display_on (display_on),
    .hsync_in   (hsync_in),
    .vsync_in   (vsync_in),
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .glyph_char (glyph_char),
    .glyph_row  (glyph_row),
    .glyph_bits (glyph_bits),
    .rgb        (rgb),
    .hsync_out  (hsync_out),
    .vsync_out  (vsync_out)
  );

  always #20 clk = ~clk;

  assign glyph_bits =
    (glyph_char == 8'h41 && glyph_row == 4'd0) ? 8'h80 :
    (glyph_char == 8'h42) ? 8'hFF : 8'h00;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    int t;
    t = 0;
    while (!wr_ready && t < 2000) begin
      tick();
      t++;
    end
    check("send_ready", {31'd0, wr_ready}, 32'd1);
    wr_valid = 1'b1;
    wr_data  = b;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic stall_len(output int n);
    n = 0;
    while (!wr_ready && n < 2000) begin
      tick();
      n++;
    end
  endtask

  task automatic read_cell(input int c, input int r, output logic [7:0] ch);
    hpos = 9'(c * 8);
    vpos = 9'(r * 16);
    tick();
    ch = glyph_char;
  endtask

  task automatic count_nonspace(input int r0, input int r1, output int bad);
    logic [7:0] ch;
    bad = 0;
    for (int r = r0; r <= r1; r++)
      for (int c = 0; c < 32; c++) begin
        read_cell(c, r, ch);
        if (ch !== 8'h20) bad++;
      end
  endtask

  task automatic pixel_at(input int h, input int v, output logic [11:0] px);
    hpos = 9'(h);
    vpos = 9'(v);
    tick();
    tick();
    px = rgb;
  endtask

  initial begin
    int n;
    int bad;
    logic [7:0] ch;
    logic [11:0] px;

    reset = 1'b1;
    hpos = 9'd0;
    vpos = 9'd0;
    display_on = 1'b1;
    hsync_in = 1'b0;
    vsync_in = 1'b0;
    wr_valid = 1'b0;
    wr_data = 8'h00;
    tick();
    tick();
    check("rst_ready", {31'd0, wr_ready}, 32'd0);
    check("rst_rgb", {20'd0, rgb}, 32'h0);
    check("rst_hsync", {31'd0, hsync_out}, 32'd0);
    check("rst_gchar", {24'd0, glyph_char}, 32'h0);
    check("rst_grow", {28'd0, glyph_row}, 32'h0);

    reset = 1'b0;
    stall_len(n);
    check("post_rst_stall", n, 480);
    count_nonspace(0, 14, bad);
    check("post_rst_cells", bad, 0);

    send(8'h41);
    check("a_col", {26'd0, dut.cur_col_q}, 32'd1);
    check("a_row", {27'd0, dut.cur_row_q}, 32'd0);
    read_cell(0, 0, ch);
    check("a_cell", {24'd0, ch}, 32'h41);

    pixel_at(8, 0, px);
    hpos = 9'd0;
    hsync_in = 1'b1;
    tick();
    check("lat_rgb_d1", {20'd0, rgb}, 32'h000);
    check("lat_hs_d1", {31'd0, hsync_out}, 32'd0);
    hpos = 9'd1;
    hsync_in = 1'b0;
    tick();
    check("lat_rgb_d2", {20'd0, rgb}, 32'h0F0);
    check("lat_hs_d2", {31'd0, hsync_out}, 32'd1);
    tick();
    check("lat_rgb_x1", {20'd0, rgb}, 32'h000);
    check("lat_hs_end", {31'd0, hsync_out}, 32'd0);

    send(8'h42);
    pixel_at(8, 11, px);
    check("b_line11", {20'd0, px}, 32'h0F0);
    pixel_at(8, 12, px);
    check("b_line12", {20'd0, px}, 32'h000);
    pixel_at(256, 0, px);
    check("col_oor", {20'd0, px}, 32'h000);
    pixel_at(0, 240, px);
    check("row_oor", {20'd0, px}, 32'h000);
    pixel_at(0, 0, px);
    check("a_pix_on", {20'd0, px}, 32'h0F0);
    display_on = 1'b0;
    pixel_at(0, 0, px);
    check("disp_off", {20'd0, px}, 32'h000);
    display_on = 1'b1;

    send(8'h0C);
    stall_len(n);
    check("ff_stall", n, 480);
    check("ff_col", {26'd0, dut.cur_col_q}, 32'd0);
    check("ff_row", {27'd0, dut.cur_row_q}, 32'd0);
    check("ff_top", {27'd0, dut.top_row_q}, 32'd0);
    count_nonspace(0, 14, bad);
    check("ff_cells", bad, 0);

    send(8'h08);
    check("bs_col0", {26'd0, dut.cur_col_q}, 32'd0);

    for (int i = 0; i < 32; i++) send(8'(8'h30 + i));
    check("wrap_col", {26'd0, dut.cur_col_q}, 32'd0);
    check("wrap_row", {27'd0, dut.cur_row_q}, 32'd1);
    read_cell(31, 0, ch);
    check("wrap_c31", {24'd0, ch}, 32'h4F);
    read_cell(0, 0, ch);
    check("wrap_c0", {24'd0, ch}, 32'h30);

    for (int i = 0; i < 5; i++) send(8'(8'h61 + i));
    check("col5", {26'd0, dut.cur_col_q}, 32'd5);
    send(8'h0D);
    check("cr_col", {26'd0, dut.cur_col_q}, 32'd0);
    for (int i = 0; i < 3; i++) send(8'(8'h66 + i));
    send(8'h08);
    check("bs_col", {26'd0, dut.cur_col_q}, 32'd2);
    read_cell(2, 1, ch);
    check("bs_noerase", {24'd0, ch}, 32'h68);
    read_cell(3, 1, ch);
    check("cr_keep", {24'd0, ch}, 32'h64);

    for (int i = 0; i < 13; i++) send(8'h0A);
    check("lf_row14", {27'd0, dut.cur_row_q}, 32'd14);
    check("lf_top0", {27'd0, dut.top_row_q}, 32'd0);
    send(8'h0A);
    stall_len(n);
    check("scroll_stall", n, 32);
    check("scroll_top", {27'd0, dut.top_row_q}, 32'd1);
    check("scroll_row", {27'd0, dut.cur_row_q}, 32'd14);
    check("scroll_col", {26'd0, dut.cur_col_q}, 32'd0);
    count_nonspace(14, 14, bad);
    check("scroll_clr", bad, 0);
    read_cell(0, 0, ch);
    check("scroll_top_line", {24'd0, ch}, 32'h66);
    hpos = 9'd0;
    vpos = 9'd239;
    tick();
    check("v239_char", {24'd0, glyph_char}, 32'h20);
    check("v239_grow", {28'd0, glyph_row}, 32'd15);

    send(8'h0A);
    for (int i = 0; i < 10; i++) tick();
    check("clrrow_busy", {31'd0, wr_ready}, 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_col", {26'd0, dut.cur_col_q}, 32'd0);
    check("mid_rst_row", {27'd0, dut.cur_row_q}, 32'd0);
    check("mid_rst_top", {27'd0, dut.top_row_q}, 32'd0);
    stall_len(n);
    check("mid_rst_stall", n, 480);
    read_cell(0, 1, ch);
    check("mid_rst_cell", {24'd0, ch}, 32'h20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
